// File: rtl/board_pkg.sv
// Shared constants, state encoding and helpers for the 6x6 card board.
package board_pkg;

   localparam int unsigned CELLS    = 36;
   localparam int unsigned COLS     = 6;
   localparam int unsigned ROWS     = 6;
   localparam int unsigned COLOUR_W = 8;
   localparam int unsigned IDX_W    = 6;
   localparam int unsigned LFSR_W   = 16;
   localparam int unsigned VIEW_W   = 14;

   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      SHUFFLE = 2'd1,
      PLAY    = 2'd2,
      CLEARED = 2'd3
   } state_t;

   // Number of set bits in a 36-cell mask.
   function automatic logic [IDX_W-1:0] popcount36(input logic [CELLS-1:0] v);
      logic [IDX_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(CELLS); i++) begin
         n = n + IDX_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/board_lfsr.sv
// 16-bit Galois LFSR; value_c shows the loaded seed in the same cycle as load.
module board_lfsr
   import board_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              step,
   input  logic [7:0]        seed_val,
   output logic [VIEW_W-1:0] value_c
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] cur;
   logic [LFSR_W-1:0] nxt;

   // Current value (seed overrides register on load) and its successor.
   always_comb begin
      cur = load ? {8'h00, seed_val} : state_q;
      nxt = cur;
      if (step) begin
         nxt = {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : '0);
      end
   end

   assign value_c = cur[VIEW_W-1:0];

   // LFSR register; reset value is any non-zero state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= LFSR_W'(1);
      else     state_q <= nxt;
   end

endmodule

// File: rtl/card_board.sv
// Card board storage, shuffle, cursor/selection owner and matcher-verdict sink.
module card_board
   import board_pkg::*;
#(
   parameter int unsigned         SHUFFLE_SWAPS = 64,
   parameter logic [COLOUR_W-1:0] SEED_DEFAULT  = 8'hA5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_game,
   input  logic [7:0]       seed,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_sel,
   input  logic             en_input,
   input  logic             ms,
   input  logic             mf,
   input  logic [IDX_W-1:0] addr,
   output logic [2:0]       r,
   output logic [2:0]       g,
   output logic [1:0]       b,
   output logic [CELLS-1:0] sel_bus,
   output logic [CELLS-1:0] hidden_bus,
   output logic [IDX_W-1:0] cursor,
   output logic             ready,
   output logic             cleared
);

   localparam int unsigned      J_W        = $clog2(SHUFFLE_SWAPS + 1);
   localparam logic [CELLS-1:0] ALL_HIDDEN = '1;

   state_t               state, state_d;
   logic [COLOUR_W-1:0]  colour [CELLS];
   logic [IDX_W-1:0]     k;
   logic [J_W-1:0]       j;
   logic                 seed_pend, ms_q, mf_q;
   logic                 lfsr_load, lfsr_step;
   logic [VIEW_W-1:0]    lfsr_c;
   logic [7:0]           seed_eff;
   logic [COLOUR_W-1:0]  fill_col;
   logic [IDX_W-1:0]     swap_i, swap_p, col_c, cursor_d;
   logic                 ms_rise, mf_rise, fill_last, shuffle_last, served;

   assign seed_eff     = (seed == 8'h00) ? SEED_DEFAULT : seed;
   assign fill_col     = (lfsr_c[7:0] == 8'h00) ? 8'hFF : lfsr_c[7:0];
   assign swap_i       = lfsr_c[5:0] % IDX_W'(CELLS);
   assign swap_p       = lfsr_c[13:8] % IDX_W'(CELLS);
   assign ms_rise      = ms & ~ms_q;
   assign mf_rise      = mf & ~mf_q;
   assign fill_last    = (k == IDX_W'(CELLS - 1));
   assign shuffle_last = (j == J_W'(SHUFFLE_SWAPS - 1));
   assign served       = (state == PLAY) || (state == CLEARED);
   assign col_c        = cursor % IDX_W'(COLS);

   board_lfsr u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .step     (lfsr_step),
      .seed_val (seed_eff),
      .value_c  (lfsr_c)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FILL;
      else     state <= state_d;
   end

   // Next state and LFSR control; new_game overrides everything.
   always_comb begin
      state_d   = state;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      if (new_game) begin
         state_d   = FILL;
         lfsr_load = 1'b1;
      end else begin
         case (state)
            FILL: begin
               lfsr_load = seed_pend;
               lfsr_step = ~k[0];
               if (fill_last) state_d = SHUFFLE;
            end
            SHUFFLE: begin
               lfsr_step = 1'b1;
               if (shuffle_last) state_d = PLAY;
            end
            PLAY:    if (hidden_bus == ALL_HIDDEN) state_d = CLEARED;
            default: state_d = state;
         endcase
      end
   end

   // Saturating cursor move, priority up > down > left > right.
   always_comb begin
      cursor_d = cursor;
      if (btn_up) begin
         if (cursor >= IDX_W'(COLS)) cursor_d = cursor - IDX_W'(COLS);
      end else if (btn_down) begin
         if (cursor < IDX_W'(CELLS - COLS)) cursor_d = cursor + IDX_W'(COLS);
      end else if (btn_left) begin
         if (col_c != '0) cursor_d = cursor - IDX_W'(1);
      end else if (btn_right) begin
         if (col_c != IDX_W'(COLS - 1)) cursor_d = cursor + IDX_W'(1);
      end
   end

   // Colour store: pair fill, then one two-cell swap per shuffle cycle.
   always_ff @(posedge clk) begin
      if (!new_game) begin
         if (state == FILL) begin
            colour[k] <= k[0] ? colour[k - IDX_W'(1)] : fill_col;
         end else if (state == SHUFFLE && swap_i != swap_p) begin
            colour[swap_i] <= colour[swap_p];
            colour[swap_p] <= colour[swap_i];
         end
      end
   end

   // Read port, counters, selection/hidden masks and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k          <= '0;
         j          <= '0;
         seed_pend  <= 1'b1;
         ms_q       <= 1'b0;
         mf_q       <= 1'b0;
         {r, g, b}  <= '0;
         sel_bus    <= '0;
         hidden_bus <= ALL_HIDDEN;
         cursor     <= '0;
         ready      <= 1'b0;
         cleared    <= 1'b0;
      end else begin
         ms_q      <= ms;
         mf_q      <= mf;
         seed_pend <= 1'b0;
         if (served && addr < IDX_W'(CELLS)) {r, g, b} <= colour[addr];
         else                                {r, g, b} <= '0;
         if (new_game) begin
            k          <= '0;
            j          <= '0;
            sel_bus    <= '0;
            hidden_bus <= ALL_HIDDEN;
            cursor     <= '0;
            ready      <= 1'b0;
            cleared    <= 1'b0;
         end else begin
            case (state)
               FILL: begin
                  k <= fill_last ? '0 : k + IDX_W'(1);
                  j <= '0;
               end
               SHUFFLE: begin
                  j <= j + J_W'(1);
                  if (shuffle_last) begin
                     hidden_bus <= '0;
                     sel_bus    <= '0;
                     cursor     <= '0;
                     ready      <= 1'b1;
                  end
               end
               PLAY: begin
                  if (hidden_bus == ALL_HIDDEN) begin
                     cleared <= 1'b1;
                  end else begin
                     cursor <= cursor_d;
                     if (ms_rise) begin
                        hidden_bus <= hidden_bus | sel_bus;
                        sel_bus    <= '0;
                     end else if (mf_rise) begin
                        sel_bus <= '0;
                     end else if (btn_sel && en_input && !hidden_bus[cursor]) begin
                        if (sel_bus[cursor])                     sel_bus[cursor] <= 1'b0;
                        else if (popcount36(sel_bus) < IDX_W'(2)) sel_bus[cursor] <= 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_card_board.sv
// Directed self-checking bench for card_board.
module tb_card_board;

   logic        clk, rst, new_game;
   logic [7:0]  seed;
   logic        btn_up, btn_down, btn_left, btn_right, btn_sel, en_input, ms, mf;
   logic [5:0]  addr;
   logic [2:0]  r, g;
   logic [1:0]  b;
   logic [35:0] sel_bus, hidden_bus;
   logic [5:0]  cursor;
   logic        ready, cleared;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  model [36];
   logic [35:0] exp_hid;
   logic [35:0] all_ones = '1;

   card_board dut (
      .clk(clk), .rst(rst), .new_game(new_game), .seed(seed),
      .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
      .btn_sel(btn_sel), .en_input(en_input), .ms(ms), .mf(mf), .addr(addr),
      .r(r), .g(g), .b(b), .sel_bus(sel_bus), .hidden_bus(hidden_bus),
      .cursor(cursor), .ready(ready), .cleared(cleared)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] lstep(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Reference board: pair fill then swaps, straight from the algorithm description.
   task automatic build_model(input logic [7:0] s);
      logic [15:0] lf;
      logic [7:0]  t;
      int          i, p;
      lf = {8'h00, (s == 8'h00) ? 8'hA5 : s};
      for (int kk = 0; kk < 36; kk++) begin
         if (kk % 2 == 0) begin
            model[kk] = (lf[7:0] == 8'h00) ? 8'hFF : lf[7:0];
            lf = lstep(lf);
         end else begin
            model[kk] = model[kk-1];
         end
      end
      for (int jj = 0; jj < 64; jj++) begin
         i = int'(lf[5:0]) % 36;
         p = int'(lf[13:8]) % 36;
         t = model[i]; model[i] = model[p]; model[p] = t;
         lf = lstep(lf);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic press(input int which);
      case (which)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         2: btn_left = 1'b1;
         3: btn_right = 1'b1;
         default: btn_sel = 1'b1;
      endcase
      tick();
      {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
   endtask

   task automatic move_to(input int t);
      for (int s = 0; s < 6; s++) begin
         if (int'(cursor) / 6 > t / 6)      press(0);
         else if (int'(cursor) / 6 < t / 6) press(1);
      end
      for (int s = 0; s < 6; s++) begin
         if (int'(cursor) % 6 > t % 6)      press(2);
         else if (int'(cursor) % 6 < t % 6) press(3);
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1; new_game = 1'b0; seed = 8'h00; addr = '0;
      {btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
      en_input = 1'b1; ms = 1'b0; mf = 1'b0;
      repeat (3) tick();
      n_cmp++; if ({r, g, b} !== 8'h00) begin $display("FAIL reset_rgb got %h want 00", {r, g, b}); n_bad++; end
      n_cmp++; if (hidden_bus !== all_ones) begin $display("FAIL reset_hidden got %h want %h", hidden_bus, all_ones); n_bad++; end
      n_cmp++; if (sel_bus !== 36'h0) begin $display("FAIL reset_sel got %h want 0", sel_bus); n_bad++; end
      n_cmp++; if ({ready, cleared, cursor} !== 8'h00) begin $display("FAIL reset_flags got %h want 00", {ready, cleared, cursor}); n_bad++; end
      rst = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 300) begin tick(); n++; end
      n_cmp++; if (n !== 100) begin $display("FAIL ready_latency got %0d want 100", n); n_bad++; end
      n_cmp++; if (hidden_bus !== 36'h0) begin $display("FAIL play_hidden got %h want 0", hidden_bus); n_bad++; end
   endtask

   task automatic test_read();
      int          cnt [256];
      int          odd, zeros;
      logic [7:0]  v;
      for (int i = 0; i < 256; i++) cnt[i] = 0;
      for (int a = 0; a < 36; a++) begin
         addr = 6'(a);
         tick();
         v = {r, g, b};
         cnt[v]++;
         n_cmp++; if (v !== model[a]) begin $display("FAIL board_cell%0d got %h want %h", a, v, model[a]); n_bad++; end
      end
      odd = 0;
      for (int i = 0; i < 256; i++) if (cnt[i] % 2 != 0) odd++;
      zeros = cnt[0];
      n_cmp++; if (odd !== 0) begin $display("FAIL even_counts got %0d odd colours want 0", odd); n_bad++; end
      n_cmp++; if (zeros !== 0) begin $display("FAIL no_zero_colour got %0d want 0", zeros); n_bad++; end
      addr = 6'd7; tick(); addr = 6'd40;
      n_cmp++; if ({r, g, b} !== model[7]) begin $display("FAIL read_addr7 got %h want %h", {r, g, b}, model[7]); n_bad++; end
      tick();
      n_cmp++; if ({r, g, b} !== 8'h00) begin $display("FAIL read_addr40 got %h want 00", {r, g, b}); n_bad++; end
   endtask

   task automatic test_cursor();
      press(2);
      n_cmp++; if (cursor !== 6'd0) begin $display("FAIL cur_left_edge got %0d want 0", cursor); n_bad++; end
      press(0);
      n_cmp++; if (cursor !== 6'd0) begin $display("FAIL cur_up_edge got %0d want 0", cursor); n_bad++; end
      repeat (5) press(3);
      n_cmp++; if (cursor !== 6'd5) begin $display("FAIL cur_right5 got %0d want 5", cursor); n_bad++; end
      press(3);
      n_cmp++; if (cursor !== 6'd5) begin $display("FAIL cur_right_edge got %0d want 5", cursor); n_bad++; end
      repeat (6) press(1);
      n_cmp++; if (cursor !== 6'd35) begin $display("FAIL cur_down6 got %0d want 35", cursor); n_bad++; end
      btn_up = 1'b1; btn_left = 1'b1; tick(); btn_up = 1'b0; btn_left = 1'b0;
      n_cmp++; if (cursor !== 6'd29) begin $display("FAIL cur_prio_up got %0d want 29", cursor); n_bad++; end
      btn_left = 1'b1; btn_right = 1'b1; tick(); btn_left = 1'b0; btn_right = 1'b0;
      n_cmp++; if (cursor !== 6'd28) begin $display("FAIL cur_prio_left got %0d want 28", cursor); n_bad++; end
   endtask

   task automatic test_select();
      move_to(3); press(4);
      n_cmp++; if (sel_bus !== 36'h8) begin $display("FAIL sel_first got %h want 8", sel_bus); n_bad++; end
      move_to(9); press(4);
      n_cmp++; if (sel_bus !== 36'h208) begin $display("FAIL sel_second got %h want 208", sel_bus); n_bad++; end
      move_to(10); press(4);
      n_cmp++; if (sel_bus !== 36'h208) begin $display("FAIL sel_third_ignored got %h want 208", sel_bus); n_bad++; end
      en_input = 1'b0; move_to(3); press(4);
      n_cmp++; if (sel_bus !== 36'h208) begin $display("FAIL sel_en_low got %h want 208", sel_bus); n_bad++; end
      en_input = 1'b1; press(4);
      n_cmp++; if (sel_bus !== 36'h200) begin $display("FAIL sel_deselect got %h want 200", sel_bus); n_bad++; end
      press(4);
      n_cmp++; if (sel_bus !== 36'h208) begin $display("FAIL sel_reselect got %h want 208", sel_bus); n_bad++; end
   endtask

   task automatic test_verdict();
      ms = 1'b1; tick();
      move_to(0); press(4);
      ms = 1'b0; tick();
      exp_hid = 36'h208;
      n_cmp++; if (hidden_bus !== exp_hid) begin $display("FAIL ms_hidden_once got %h want %h", hidden_bus, exp_hid); n_bad++; end
      n_cmp++; if (sel_bus !== 36'h1) begin $display("FAIL ms_held_sel got %h want 1", sel_bus); n_bad++; end
      move_to(3); press(4);
      n_cmp++; if (sel_bus !== 36'h1) begin $display("FAIL sel_hidden_cell got %h want 1", sel_bus); n_bad++; end
      move_to(1); press(4);
      mf = 1'b1; tick(); mf = 1'b0; tick();
      n_cmp++; if ({hidden_bus, sel_bus} !== {exp_hid, 36'h0}) begin $display("FAIL mf_clear got %h/%h want %h/0", hidden_bus, sel_bus, exp_hid); n_bad++; end
      btn_sel = 1'b1; mf = 1'b1; tick(); btn_sel = 1'b0; mf = 1'b0; tick();
      n_cmp++; if (sel_bus !== 36'h0) begin $display("FAIL verdict_over_sel got %h want 0", sel_bus); n_bad++; end
      move_to(0); press(4); move_to(1); press(4);
      ms = 1'b1; mf = 1'b1; tick(); ms = 1'b0; mf = 1'b0; tick();
      exp_hid = exp_hid | 36'h3;
      n_cmp++; if ({hidden_bus, sel_bus} !== {exp_hid, 36'h0}) begin $display("FAIL ms_beats_mf got %h/%h want %h/0", hidden_bus, sel_bus, exp_hid); n_bad++; end
   endtask

   task automatic test_clear();
      int free [$];
      int last_b;
      for (int c = 0; c < 36; c++) if (!exp_hid[c]) free.push_back(c);
      last_b = 0;
      for (int p = 0; p + 1 < free.size(); p += 2) begin
         move_to(free[p]); press(4);
         move_to(free[p+1]); press(4);
         last_b = free[p+1];
         if (p + 2 >= free.size()) begin
            n_cmp++; if (cleared !== 1'b0) begin $display("FAIL cleared_early got %b want 0", cleared); n_bad++; end
         end
         ms = 1'b1; tick(); ms = 1'b0; tick();
         exp_hid[free[p]] = 1'b1; exp_hid[free[p+1]] = 1'b1;
         n_cmp++; if (hidden_bus !== exp_hid) begin $display("FAIL hide_pair%0d got %h want %h", p / 2, hidden_bus, exp_hid); n_bad++; end
      end
      tick();
      n_cmp++; if ({cleared, ready} !== 2'b11) begin $display("FAIL cleared_flag got %b want 11", {cleared, ready}); n_bad++; end
      addr = 6'd0; tick();
      n_cmp++; if ({r, g, b} !== model[0]) begin $display("FAIL cleared_read got %h want %h", {r, g, b}, model[0]); n_bad++; end
      press(0); press(4);
      n_cmp++; if ({cursor, sel_bus} !== {6'(last_b), 36'h0}) begin $display("FAIL cleared_ignore got %0d/%h want %0d/0", cursor, sel_bus, last_b); n_bad++; end
   endtask

   task automatic test_new_game();
      int n;
      seed = 8'h3C; new_game = 1'b1; tick(); new_game = 1'b0;
      n_cmp++; if ({ready, cleared, hidden_bus, sel_bus} !== {2'b00, all_ones, 36'h0}) begin $display("FAIL ng_state got %b%b %h %h want 00 all-ones 0", ready, cleared, hidden_bus, sel_bus); n_bad++; end
      addr = 6'd5;
      repeat (50) tick();
      n_cmp++; if ({ready, r, g, b} !== 9'h000) begin $display("FAIL mid_shuffle got %h want 000", {ready, r, g, b}); n_bad++; end
      seed = 8'h00; new_game = 1'b1; tick(); new_game = 1'b0;
      n_cmp++; if (ready !== 1'b0) begin $display("FAIL ng_mid_shuffle_ready got %b want 0", ready); n_bad++; end
      n = 0;
      while (ready !== 1'b1 && n < 300) begin tick(); n++; end
      n_cmp++; if (n !== 100) begin $display("FAIL ng_restart_latency got %0d want 100", n); n_bad++; end
      for (int a = 0; a < 36; a += 7) begin
         addr = 6'(a); tick();
         n_cmp++; if ({r, g, b} !== model[a]) begin $display("FAIL ng_board_cell%0d got %h want %h", a, {r, g, b}, model[a]); n_bad++; end
      end
   endtask

   initial begin
      build_model(8'h00);
      test_reset();
      test_read();
      test_cursor();
      test_select();
      test_verdict();
      test_clear();
      test_new_game();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
